mem_copy_dma: RTL and testbench

Block-copy engine acting as initiator on the read/write port of the on-chip byte-addressed memory. It copies `length` bytes from `src_addr` to `dst_addr` in WORD, HALFWORD or BYTE units. It uses the memory's combinational read, registered write and error flags. It sits beside the CPU as a simple offload engine, controlled by a start/busy/done handshake.

---
 rtl/mem_copy_dma_pkg.sv | 28 ++
 rtl/mem_copy_dma.sv | 167 ++++++++++++++++
 tb/tb_mem_copy_dma.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_dma_pkg.sv
// Shared types for the block-copy DMA engine: transfer unit, error status
// and the unit-to-step-size helper.
package mem_copy_dma_pkg;

  typedef enum logic [1:0] {
    BYTE     = 2'd0,
    HALFWORD = 2'd1,
    WORD     = 2'd2
  } tsize_e;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_LEN   = 3'd1,
    ERR_RD    = 3'd2,
    ERR_WR    = 3'd3,
    ERR_ABORT = 3'd4
  } dma_err_e;

  // Bytes moved per unit; any unused encoding behaves as BYTE.
  function automatic logic [2:0] step_size(input tsize_e t);
    case (t)
      WORD:     return 3'd4;
      HALFWORD: return 3'd2;
      default:  return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mem_copy_dma.sv
// Block-copy engine: reads one unit from src, writes it to dst, checks the
// registered write error, and repeats until length bytes are moved.
module mem_copy_dma
  import mem_copy_dma_pkg::*;
#(
  parameter int N  = 1024,
  parameter int LW = 16,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [LW-1:0] length,
  input  tsize_e        unit,
  output logic          busy,
  output logic          done,
  output dma_err_e      err,
  output logic [AW-1:0] err_addr,
  output logic [AW-1:0] mem_address,
  output tsize_e        mem_tsize,
  output logic          mem_write,
  output logic [31:0]   mem_write_data,
  input  logic [31:0]   mem_data,
  input  logic          mem_rerror,
  input  logic          mem_werror
);

  // Handshake: start is a single-cycle request honoured only while busy=0;
  // busy stays high until the engine is back in IDLE, and done pulses for
  // one cycle (with busy still high) only when every unit was copied.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_WCHK  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e        state, state_next;
  logic [AW-1:0] src_q, dst_q;
  logic [LW-1:0] rem_q;
  tsize_e        unit_q;
  logic [31:0]   buf_q;

  logic [AW-1:0] step_a;
  logic [LW-1:0] step_l;
  logic [LW-1:0] start_mask;
  logic          len_bad;

  assign step_a     = AW'(step_size(unit_q));
  assign step_l     = LW'(step_size(unit_q));
  assign start_mask = LW'(step_size(unit)) - LW'(1);
  assign len_bad    = (length & start_mask) != '0;

  assign mem_tsize      = unit_q;
  assign mem_write_data = buf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (length == '0)  state_next = S_DONE;
          else if (len_bad)  state_next = S_IDLE;
          else               state_next = S_READ;
        end
      end
      S_READ: begin
        if (abort || mem_rerror) state_next = S_IDLE;
        else                     state_next = S_WRITE;
      end
      S_WRITE: state_next = abort ? S_IDLE : S_WCHK;
      S_WCHK: begin
        if (abort || mem_werror) state_next = S_IDLE;
        else if (rem_q == step_l) state_next = S_DONE;
        else                      state_next = S_READ;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    case (state)
      S_READ: begin
        busy        = 1'b1;
        mem_address = src_q;
      end
      S_WRITE: begin
        busy        = 1'b1;
        mem_address = dst_q;
        mem_write   = 1'b1;
      end
      S_WCHK: busy = 1'b1;
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and status; abort wins over read/write errors in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q    <= '0;
      dst_q    <= '0;
      rem_q    <= '0;
      unit_q   <= WORD;
      buf_q    <= '0;
      err      <= ERR_NONE;
      err_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            src_q    <= src_addr;
            dst_q    <= dst_addr;
            rem_q    <= length;
            unit_q   <= unit;
            err_addr <= '0;
            err      <= (length != '0 && len_bad) ? ERR_LEN : ERR_NONE;
          end
        end
        S_READ: begin
          if (abort) begin
            err <= ERR_ABORT;
          end else if (mem_rerror) begin
            err      <= ERR_RD;
            err_addr <= src_q;
          end else begin
            buf_q <= mem_data;
          end
        end
        S_WRITE: begin
          if (abort) err <= ERR_ABORT;
        end
        S_WCHK: begin
          if (abort) begin
            err <= ERR_ABORT;
          end else if (mem_werror) begin
            err      <= ERR_WR;
            err_addr <= dst_q;
          end else begin
            src_q <= src_q + step_a;
            dst_q <= dst_q + step_a;
            rem_q <= rem_q - step_l;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma with a behavioural byte memory responder
// (combinational read, registered write and write-error flag).
module tb_mem_copy_dma;
  import mem_copy_dma_pkg::*;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort;
  logic [AW-1:0] src_addr, dst_addr;
  logic [15:0]   length;
  tsize_e        unit;
  logic          busy, done;
  dma_err_e      err;
  logic [AW-1:0] err_addr;
  logic [AW-1:0] mem_address;
  tsize_e        mem_tsize;
  logic          mem_write;
  logic [31:0]   mem_write_data;
  logic [31:0]   mem_data;
  logic          mem_rerror;
  logic          mem_werror;

  int n_tests = 0;
  int n_fail  = 0;

  mem_copy_dma #(.N(1024), .LW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .unit(unit),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr),
    .mem_address(mem_address), .mem_tsize(mem_tsize), .mem_write(mem_write),
    .mem_write_data(mem_write_data), .mem_data(mem_data),
    .mem_rerror(mem_rerror), .mem_werror(mem_werror)
  );

  always #5 clk = ~clk;

  // ---------------- memory responder ----------------
  logic [7:0]    mem [0:1023];
  logic [AW-1:0] a1, a2, a3;
  logic          pl_we;
  logic [AW-1:0] pl_addr;
  logic [7:0]    pl_data;

  assign a1 = mem_address + 10'd1;
  assign a2 = mem_address + 10'd2;
  assign a3 = mem_address + 10'd3;

  always_comb begin
    mem_rerror = 1'b0;
    mem_data   = '0;
    case (mem_tsize)
      BYTE: mem_data = {24'h0, mem[mem_address]};
      HALFWORD: begin
        mem_rerror = mem_address[0];
        mem_data   = {16'h0, mem[a1], mem[mem_address]};
      end
      default: begin
        mem_rerror = |mem_address[1:0];
        mem_data   = {mem[a3], mem[a2], mem[a1], mem[mem_address]};
      end
    endcase
  end

  always @(posedge clk) begin
    mem_werror <= 1'b0;
    if (pl_we) begin
      mem[pl_addr] <= pl_data;
    end else if (mem_write) begin
      case (mem_tsize)
        BYTE: mem[mem_address] <= mem_write_data[7:0];
        HALFWORD: begin
          if (mem_address[0]) mem_werror <= 1'b1;
          else begin
            mem[mem_address] <= mem_write_data[7:0];
            mem[a1]          <= mem_write_data[15:8];
          end
        end
        default: begin
          if (|mem_address[1:0]) mem_werror <= 1'b1;
          else begin
            mem[mem_address] <= mem_write_data[7:0];
            mem[a1]          <= mem_write_data[15:8];
            mem[a2]          <= mem_write_data[23:16];
            mem[a3]          <= mem_write_data[31:24];
          end
        end
      endcase
    end
  end

  // ---------------- activity monitor / scoreboard ----------------
  logic          mon_clr;
  int            wr_cnt, done_cnt, busy_cnt;
  logic [AW-1:0] wr_addr_q[$];
  logic [AW-1:0] exp_q[$];

  always @(posedge clk) begin
    if (mon_clr) begin
      wr_cnt   = 0;
      done_cnt = 0;
      busy_cnt = 0;
      wr_addr_q.delete();
    end else begin
      if (mem_write) begin
        wr_cnt = wr_cnt + 1;
        wr_addr_q.push_back(mem_address);
      end
      if (done) done_cnt = done_cnt + 1;
      if (busy) busy_cnt = busy_cnt + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mon();
    @(negedge clk);
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] addr, input logic [7:0] data);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = addr; pl_data = data;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic wait_idle(input int k0, input int budget, inout int done_cyc);
    int  k;
    bit  fin;
    k = k0; fin = 1'b0;
    while (!fin && k < budget) begin
      k++;
      if (done && done_cyc == 0) done_cyc = k;
      if (!busy) fin = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
  endtask

  // done_cyc = samples after the start edge (1 = right after it) where done is seen; 0 if never
  task automatic run_xfer(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [15:0] len, input tsize_e u, output int done_cyc);
    @(negedge clk);
    src_addr = s; dst_addr = d; length = len; unit = u; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_cyc = 0;
    wait_idle(0, 200, done_cyc);
  endtask

  task automatic check_wr_addrs(input string name);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (i >= wr_addr_q.size() || wr_addr_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s wr_addr[%0d]: got %h expected %h", name, i,
                 (i < wr_addr_q.size()) ? wr_addr_q[i] : 10'h0, exp_q[i]);
      end
    end
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b expected 0", done); end
    n_tests++; if (err !== ERR_NONE) begin n_fail++; $display("FAIL reset err: got %0d expected 0", err); end
    n_tests++; if (err_addr !== 10'h0) begin n_fail++; $display("FAIL reset err_addr: got %h expected 0", err_addr); end
    n_tests++; if (mem_address !== 10'h0) begin n_fail++; $display("FAIL reset mem_address: got %h expected 0", mem_address); end
    n_tests++; if (mem_tsize !== WORD) begin n_fail++; $display("FAIL reset mem_tsize: got %0d expected %0d", mem_tsize, WORD); end
    n_tests++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL reset mem_write: got %b expected 0", mem_write); end
    n_tests++; if (mem_write_data !== 32'h0) begin n_fail++; $display("FAIL reset mem_write_data: got %h expected 0", mem_write_data); end
  endtask

  task automatic test_word_copy();
    int dc;
    clear_mon();
    for (int i = 0; i < 4; i++) exp_q.push_back(10'h100 + 10'(4 * i));
    run_xfer(10'h000, 10'h100, 16'd16, WORD, dc);
    n_tests++; if (dc !== 13) begin n_fail++; $display("FAIL word done_cycle: got %0d expected 13", dc); end
    n_tests++; if (wr_cnt !== 4) begin n_fail++; $display("FAIL word write_strobes: got %0d expected 4", wr_cnt); end
    n_tests++; if (err !== ERR_NONE) begin n_fail++; $display("FAIL word err: got %0d expected 0", err); end
    check_wr_addrs("word");
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (mem[10'h100 + 10'(i)] !== 8'(i)) begin
        n_fail++;
        $display("FAIL word mem[%h]: got %h expected %h", 10'h100 + 10'(i), mem[10'h100 + 10'(i)], 8'(i));
      end
    end
  endtask

  task automatic test_byte_wrap();
    int         dc;
    logic [7:0] exp_b [4];
    exp_b = '{8'hA0, 8'hA1, 8'h00, 8'h01};
    clear_mon();
    for (int i = 0; i < 4; i++) exp_q.push_back(10'h010 + 10'(i));
    run_xfer(10'h3FE, 10'h010, 16'd4, BYTE, dc);
    n_tests++; if (dc !== 13) begin n_fail++; $display("FAIL wrap done_cycle: got %0d expected 13", dc); end
    n_tests++; if (err !== ERR_NONE) begin n_fail++; $display("FAIL wrap err: got %0d expected 0", err); end
    check_wr_addrs("wrap");
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (mem[10'h010 + 10'(i)] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL wrap mem[%h]: got %h expected %h", 10'h010 + 10'(i), mem[10'h010 + 10'(i)], exp_b[i]);
      end
    end
  endtask

  task automatic test_misaligned_src();
    int dc;
    clear_mon();
    run_xfer(10'h002, 10'h140, 16'd4, WORD, dc);
    n_tests++; if (err !== ERR_RD) begin n_fail++; $display("FAIL rd_err err: got %0d expected %0d", err, ERR_RD); end
    n_tests++; if (err_addr !== 10'h002) begin n_fail++; $display("FAIL rd_err err_addr: got %h expected 002", err_addr); end
    n_tests++; if (wr_cnt !== 0) begin n_fail++; $display("FAIL rd_err write_strobes: got %0d expected 0", wr_cnt); end
    n_tests++; if (dc !== 0 || done_cnt !== 0) begin n_fail++; $display("FAIL rd_err done: got %0d expected 0", done_cnt); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_err busy: got %b expected 0", busy); end
  endtask

  task automatic test_misaligned_dst();
    int dc;
    clear_mon();
    run_xfer(10'h000, 10'h101, 16'd2, HALFWORD, dc);
    n_tests++; if (err !== ERR_WR) begin n_fail++; $display("FAIL wr_err err: got %0d expected %0d", err, ERR_WR); end
    n_tests++; if (err_addr !== 10'h101) begin n_fail++; $display("FAIL wr_err err_addr: got %h expected 101", err_addr); end
    n_tests++; if (done_cnt !== 0) begin n_fail++; $display("FAIL wr_err done: got %0d expected 0", done_cnt); end
    n_tests++; if (mem[10'h101] !== 8'h01 || mem[10'h102] !== 8'h02) begin
      n_fail++; $display("FAIL wr_err dst_unchanged: got %h %h expected 01 02", mem[10'h101], mem[10'h102]);
    end
  endtask

  task automatic test_length();
    int dc;
    clear_mon();
    run_xfer(10'h000, 10'h180, 16'd6, WORD, dc);
    n_tests++; if (err !== ERR_LEN) begin n_fail++; $display("FAIL len6 err: got %0d expected %0d", err, ERR_LEN); end
    n_tests++; if (wr_cnt !== 0 || busy_cnt !== 0) begin
      n_fail++; $display("FAIL len6 activity: got writes=%0d busy=%0d expected 0 0", wr_cnt, busy_cnt);
    end
    clear_mon();
    run_xfer(10'h000, 10'h180, 16'd0, WORD, dc);
    n_tests++; if (dc !== 1) begin n_fail++; $display("FAIL len0 done_cycle: got %0d expected 1", dc); end
    n_tests++; if (err !== ERR_NONE) begin n_fail++; $display("FAIL len0 err: got %0d expected 0", err); end
    n_tests++; if (wr_cnt !== 0 || done_cnt !== 1) begin
      n_fail++; $display("FAIL len0 activity: got writes=%0d dones=%0d expected 0 1", wr_cnt, done_cnt);
    end
  endtask

  task automatic test_start_while_busy();
    int dc;
    clear_mon();
    @(negedge clk);
    src_addr = 10'h00C; dst_addr = 10'h180; length = 16'd4; unit = WORD; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dc = 0;
    @(posedge clk); #1;
    src_addr = 10'h000; dst_addr = 10'h1C0; length = 16'd16; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(2, 200, dc);
    n_tests++; if (dc !== 4) begin n_fail++; $display("FAIL busy_start done_cycle: got %0d expected 4", dc); end
    n_tests++; if (wr_cnt !== 1) begin n_fail++; $display("FAIL busy_start write_strobes: got %0d expected 1", wr_cnt); end
    n_tests++; if (mem[10'h180] !== 8'h0C || mem[10'h183] !== 8'h0F) begin
      n_fail++; $display("FAIL busy_start data: got %h %h expected 0c 0f", mem[10'h180], mem[10'h183]);
    end
  endtask

  task automatic test_abort();
    int dc;
    clear_mon();
    @(negedge clk);
    src_addr = 10'h000; dst_addr = 10'h200; length = 16'd16; unit = WORD; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_tests++; if (err !== ERR_ABORT) begin n_fail++; $display("FAIL abort err: got %0d expected %0d", err, ERR_ABORT); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort busy: got %b expected 0", busy); end
    n_tests++; if (wr_cnt !== 1 || done_cnt !== 0) begin
      n_fail++; $display("FAIL abort activity: got writes=%0d dones=%0d expected 1 0", wr_cnt, done_cnt);
    end
    n_tests++; if (mem[10'h200] !== 8'h00 || mem[10'h203] !== 8'h03 || mem[10'h204] !== 8'hCC) begin
      n_fail++; $display("FAIL abort data: got %h %h %h expected 00 03 cc", mem[10'h200], mem[10'h203], mem[10'h204]);
    end
    // abort while idle leaves status alone
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    n_tests++; if (err !== ERR_ABORT || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_abort: got err=%0d busy=%b expected 4 0", err, busy);
    end
    clear_mon();
    run_xfer(10'h004, 10'h204, 16'd4, WORD, dc);
    n_tests++; if (dc !== 4 || err !== ERR_NONE) begin
      n_fail++; $display("FAIL after_abort: got done_cycle=%0d err=%0d expected 4 0", dc, err);
    end
    n_tests++; if (mem[10'h204] !== 8'h04 || mem[10'h207] !== 8'h07) begin
      n_fail++; $display("FAIL after_abort data: got %h %h expected 04 07", mem[10'h204], mem[10'h207]);
    end
  endtask

  task automatic test_reset_mid_copy();
    clear_mon();
    @(negedge clk);
    src_addr = 10'h008; dst_addr = 10'h300; length = 16'd4; unit = HALFWORD; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (mem_write !== 1'b1 || mem_write_data !== 32'h0000_0908) begin
      n_fail++; $display("FAIL mid_write: got we=%b data=%h expected 1 00000908", mem_write, mem_write_data);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b0 || done !== 1'b0 || mem_write !== 1'b0) begin
      n_fail++; $display("FAIL async_rst ctrl: got busy=%b done=%b we=%b expected 0 0 0", busy, done, mem_write);
    end
    n_tests++; if (mem_address !== 10'h0 || mem_tsize !== WORD || mem_write_data !== 32'h0) begin
      n_fail++; $display("FAIL async_rst port: got addr=%h tsize=%0d data=%h expected 000 2 0", mem_address, mem_tsize, mem_write_data);
    end
    n_tests++; if (err !== ERR_NONE || err_addr !== 10'h0) begin
      n_fail++; $display("FAIL async_rst status: got err=%0d err_addr=%h expected 0 000", err, err_addr);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (busy !== 1'b0 || wr_cnt !== 0) begin
      n_fail++; $display("FAIL post_rst: got busy=%b writes=%0d expected 0 0", busy, wr_cnt);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0; unit = WORD;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0; mon_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); rst_n = 1'b1; mon_clr = 1'b0;

    for (int i = 0; i < 16; i++) preload(10'(i), 8'(i));
    preload(10'h3FE, 8'hA0);
    preload(10'h3FF, 8'hA1);
    for (int i = 0; i < 16; i++) preload(10'h200 + 10'(i), 8'hCC);

    test_word_copy();
    test_byte_wrap();
    test_misaligned_src();
    test_misaligned_dst();
    test_length();
    test_start_while_busy();
    test_abort();
    test_reset_mid_copy();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
